// File: rtl/fsm_vector_sequencer.sv
// Plays a host-loaded {rst,w,expz} vector table into a single-input Moore FSM,
// checks its z one cycle behind each vector and logs the mismatches.
module fsm_vector_sequencer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned ERR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [2:0]        load_data,
    input  logic [ADDR_W:0]   num_vec,
    input  logic              start,
    output logic              dut_reset,
    output logic              dut_w,
    input  logic              dut_z,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [ERR_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_idx
);

    localparam int unsigned NV_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        table_q [DEPTH];
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              chk_valid_q, chk_valid_d;
    logic              chk_exp_q, chk_exp_d;
    logic [ADDR_W-1:0] chk_idx_q, chk_idx_d;
    logic              dut_reset_q, dut_reset_d;
    logic              dut_w_q, dut_w_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mismatch_q, mismatch_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              fev_q, fev_d;
    logic [ADDR_W-1:0] fei_q, fei_d;

    logic [NV_W-1:0]   n_clamp;
    logic [2:0]        rd0;

    // Table write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (load_en && !busy_q) begin
            table_q[load_addr] <= load_data;
        end
    end

    always_comb begin
        n_clamp = (num_vec > NV_W'(DEPTH)) ? NV_W'(DEPTH) : num_vec;
        // Entry 0 is launched on the start edge, so forward a same-cycle write.
        rd0     = (load_en && !busy_q && load_addr == '0) ? load_data : table_q[0];
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        chk_valid_d = 1'b0;
        chk_exp_d   = table_q[cur_q][0];
        chk_idx_d   = cur_q;
        dut_reset_d = 1'b1;
        dut_w_d     = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        mismatch_d  = 1'b0;
        err_d       = err_q;
        fev_d       = fev_q;
        fei_d       = fei_q;

        // z now reflects the vector launched two edges ago.
        if (chk_valid_q && (dut_z != chk_exp_q)) begin
            mismatch_d = 1'b1;
            if (err_q != '1) begin
                err_d = err_q + ERR_W'(1);
            end
            if (!fev_q) begin
                fev_d = 1'b1;
                fei_d = chk_idx_q;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    err_d = '0;
                    fev_d = 1'b0;
                    fei_d = '0;
                    if (n_clamp == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = RUN;
                        busy_d      = 1'b1;
                        done_d      = 1'b0;
                        cur_d       = '0;
                        last_d      = ADDR_W'(n_clamp - NV_W'(1));
                        dut_reset_d = rd0[2];
                        dut_w_d     = rd0[1];
                    end
                end
            end
            RUN: begin
                chk_valid_d = 1'b1;
                if (cur_q == last_q) begin
                    state_d = DRAIN;
                end else begin
                    cur_d       = cur_q + ADDR_W'(1);
                    dut_reset_d = table_q[cur_q + ADDR_W'(1)][2];
                    dut_w_d     = table_q[cur_q + ADDR_W'(1)][1];
                end
            end
            DRAIN: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            chk_valid_q <= 1'b0;
            chk_exp_q   <= 1'b0;
            chk_idx_q   <= '0;
            dut_reset_q <= 1'b1;
            dut_w_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mismatch_q  <= 1'b0;
            err_q       <= '0;
            fev_q       <= 1'b0;
            fei_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            chk_valid_q <= chk_valid_d;
            chk_exp_q   <= chk_exp_d;
            chk_idx_q   <= chk_idx_d;
            dut_reset_q <= dut_reset_d;
            dut_w_q     <= dut_w_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mismatch_q  <= mismatch_d;
            err_q       <= err_d;
            fev_q       <= fev_d;
            fei_q       <= fei_d;
        end
    end

    assign dut_reset       = dut_reset_q;
    assign dut_w           = dut_w_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign mismatch        = mismatch_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_fsm_vector_sequencer.sv
// Scoreboard bench for fsm_vector_sequencer driving a z<=reset?0:w Moore model.
module tb_fsm_vector_sequencer;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned ERR_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [2:0]        load_data;
    logic [ADDR_W:0]   num_vec;
    logic              start;
    logic              dut_reset;
    logic              dut_w;
    logic              dut_z = 1'b0;
    logic              busy;
    logic              done;
    logic              mismatch;
    logic [ERR_W-1:0]  err_count;
    logic              first_err_valid;
    logic [ADDR_W-1:0] first_err_idx;

    fsm_vector_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ERR_W(ERR_W)) u_dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .num_vec(num_vec), .start(start),
        .dut_reset(dut_reset), .dut_w(dut_w), .dut_z(dut_z), .busy(busy),
        .done(done), .mismatch(mismatch), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    // Target FSM model.
    always @(posedge clk) dut_z <= dut_reset ? 1'b0 : dut_w;

    typedef struct {
        int          busy_len;
        int          mm_cnt;
        int          first_mm;
        logic [31:0] w_bits;
        logic [31:0] r_bits;
        int          err;
        int          fev;
        int          fei;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic rec_t mk_rec(input int bl, input int mm, input int fm,
                                    input logic [31:0] wb, input logic [31:0] rb,
                                    input int err, input int fev, input int fei);
        rec_t r;
        r.busy_len = bl; r.mm_cnt = mm; r.first_mm = fm; r.w_bits = wb;
        r.r_bits = rb; r.err = err; r.fev = fev; r.fei = fei;
        return r;
    endfunction

    // Monitor: accumulates one run from first busy cycle to the done rise.
    int          m_off, m_bl, m_mm, m_first;
    logic [31:0] m_wb, m_rb;
    bit          m_coll;
    logic        m_prev_done;
    rec_t        got, req;

    always @(negedge clk) begin
        if (reset) begin
            m_coll = 0; m_off = 0; m_bl = 0; m_mm = 0; m_first = -1;
            m_wb = '0; m_rb = '0; m_prev_done = 1'b0;
        end else begin
            if (!m_coll && busy) begin
                m_coll = 1; m_off = 0;
            end
            if (m_coll) begin
                if (busy) begin
                    m_wb[m_off] = dut_w;
                    m_rb[m_off] = dut_reset;
                    m_bl++;
                end
                if (mismatch) begin
                    if (m_mm == 0) m_first = m_off;
                    m_mm++;
                end
                m_off++;
            end else if (mismatch) begin
                check_int("stray_mismatch", 1, 0);
            end
            if (done && !m_prev_done) begin
                if (exp_q.size() == 0) begin
                    check_int("unexpected_done", 1, 0);
                end else begin
                    req = exp_q.pop_front();
                    got = mk_rec(m_bl, m_mm, m_first, m_wb, m_rb, int'(err_count),
                                 int'(first_err_valid), int'(first_err_idx));
                    check_int("busy_len",        got.busy_len,     req.busy_len);
                    check_int("mismatch_pulses", got.mm_cnt,       req.mm_cnt);
                    check_int("first_pulse_cyc", got.first_mm,     req.first_mm);
                    check_int("dut_w_seq",       int'(got.w_bits), int'(req.w_bits));
                    check_int("dut_reset_seq",   int'(got.r_bits), int'(req.r_bits));
                    check_int("err_count",       got.err,          req.err);
                    check_int("first_err_valid", got.fev,          req.fev);
                    check_int("first_err_idx",   got.fei,          req.fei);
                end
                m_coll = 0; m_off = 0; m_bl = 0; m_mm = 0; m_first = -1;
                m_wb = '0; m_rb = '0;
            end
            m_prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input int addr, input logic [2:0] data);
        load_en = 1'b1; load_addr = ADDR_W'(addr); load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    task automatic run_start(input int nv);
        num_vec = (ADDR_W+1)'(nv); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            tick();
        end
        check_int("done_within_budget", int'(done), 1);
        tick();
    endtask

    task automatic run_full(input int nv, input rec_t r);
        exp_q.push_back(r);
        run_start(nv);
        wait_done();
    endtask

    task automatic check_reset_state();
        check_int("rst_dut_reset", int'(dut_reset), 1);
        check_int("rst_dut_w",     int'(dut_w), 0);
        check_int("rst_busy",      int'(busy), 0);
        check_int("rst_done",      int'(done), 0);
        check_int("rst_mismatch",  int'(mismatch), 0);
        check_int("rst_err",       int'(err_count), 0);
        check_int("rst_fev",       int'(first_err_valid), 0);
        check_int("rst_fei",       int'(first_err_idx), 0);
    endtask

    rec_t rec1, rec2, rec3, rec6a, rec6b;

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        num_vec = '0; start = 1'b0;
        rec1  = mk_rec(5, 0, -1, 32'h0A, 32'h11, 0, 0, 0);
        rec2  = mk_rec(5, 1,  4, 32'h0A, 32'h11, 1, 1, 2);
        rec3  = mk_rec(0, 0, -1, 32'h00, 32'h00, 0, 0, 0);
        rec6a = mk_rec(9, 8,  2, 32'hAA, 32'h100, 3, 1, 0);
        rec6b = mk_rec(17, 8, 2, 32'hAA, 32'h10000, 3, 1, 0);
        repeat (3) tick();
        check_reset_state();
        reset = 1'b0;
        tick();

        // 1: clean run
        load_entry(0, 3'b100); load_entry(1, 3'b011);
        load_entry(2, 3'b000); load_entry(3, 3'b011);
        run_full(4, rec1);

        // 2: entry 2 expects the wrong z
        load_entry(2, 3'b001);
        run_full(4, rec2);

        // 3: zero-length run from a freshly reset sequencer
        reset = 1'b1; tick(); reset = 1'b0;
        check_reset_state();
        run_full(0, rec3);
        load_entry(2, 3'b000);

        // 4: reset during cycle 2, then rerun with the retained table
        run_start(4);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_int("midrst_busy",      int'(busy), 0);
        check_int("midrst_done",      int'(done), 0);
        check_int("midrst_dut_reset", int'(dut_reset), 1);
        check_int("midrst_err",       int'(err_count), 0);
        tick();
        run_full(4, rec1);

        // 5: start and load while busy are ignored
        exp_q.push_back(rec1);
        run_start(4);
        tick();
        start = 1'b1; load_en = 1'b1; load_addr = '0; load_data = 3'b010; num_vec = 5'd2;
        tick();
        start = 1'b0; load_en = 1'b0;
        wait_done();
        run_full(4, rec1);

        // 6: every expz wrong on 8 entries, then a clamped 20-vector run
        for (int i = 0; i < 8; i++) begin
            load_entry(i, {1'b0, i[0], ~i[0]});
        end
        for (int i = 8; i < 16; i++) begin
            load_entry(i, 3'b000);
        end
        run_full(8, rec6a);
        run_full(20, rec6b);

        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
